// File: rtl/ad9783_pkg.sv
// ad9783_pkg: shared state encoding, register-file geometry and instruction field positions.
package ad9783_pkg;
    typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_e;
    localparam int ADDR_W = 5;
    localparam int N_REG = 32;
    localparam int INSTR_RW = 7;
    localparam int INSTR_N_HI = 6;
    localparam int INSTR_N_LO = 5;
    localparam logic [7:0] REG_RST = 8'h00;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with rise/fall pulses from the last two synchronized samples.
module spi_edge_sync #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic prev_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign q_o = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/ad9783_spi_responder.sv
// ad9783_spi_responder: oversampled AD9783 SPI slave with 32x8 register file; AD9783_SPI_READBACK_EN enables reads.
module ad9783_spi_responder
    import ad9783_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              spi_scs_in,
    input  logic              spi_sck_in,
    input  logic              spi_sdo_in,
    output logic              spi_sdi_out,
    input  logic [ADDR_W-1:0] reg_addr_in,
    output logic [7:0]        reg_data_out,
    output logic              wr_stb_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out,
    output logic              busy_out
);
    logic scs_s, scs_rise, scs_fall, sck_s, sck_rise, sck_fall, sdo_s, sdo_rise, sdo_fall;
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scs (
        .clk_i(clk_in), .rst_n_i(rst_n_in), .d_i(spi_scs_in),
        .q_o(scs_s), .rise_o(scs_rise), .fall_o(scs_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk_i(clk_in), .rst_n_i(rst_n_in), .d_i(spi_sck_in),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdo (
        .clk_i(clk_in), .rst_n_i(rst_n_in), .d_i(spi_sdo_in),
        .q_o(sdo_s), .rise_o(sdo_rise), .fall_o(sdo_fall));
    state_e state_q, state_d;
    logic [7:0] shin_q, shin_d, next_byte;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d, nb_q, nb_d;
    logic rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, reg_data_q;
    logic wr_stb_q, wr_stb_d;
    logic [7:0] regs_q [N_REG];
    assign next_byte = {shin_q[6:0], sdo_s};
`ifdef AD9783_SPI_READBACK_EN
    logic [7:0] shout_q, shout_d;
    logic [2:0] fbit_q, fbit_d;
    logic sdi_q, sdi_d;
    // First fall of each byte loads the register; later falls shift the copy out MSB first.
    always_comb begin
        shout_d = shout_q;
        fbit_d = fbit_q;
        sdi_d = sdi_q;
        if (state_q != DATA) begin
            fbit_d = 3'd0;
            sdi_d = 1'b0;
        end else if (rw_q && sck_fall) begin
            {sdi_d, shout_d} = (fbit_q == 3'd0) ? {regs_q[addr_q], 1'b0} : {shout_q, 1'b0};
            fbit_d = fbit_q + 3'd1;
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shout_q <= 8'd0;
            fbit_q <= 3'd0;
            sdi_q <= 1'b0;
        end else begin
            shout_q <= shout_d;
            fbit_q <= fbit_d;
            sdi_q <= sdi_d;
        end
    end
    assign spi_sdi_out = sdi_q & (state_q == DATA);
`else
    assign spi_sdi_out = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        shin_d = shin_q;
        bit_d = bit_q;
        byte_d = byte_q;
        nb_d = nb_q;
        rw_d = rw_q;
        addr_d = addr_q;
        wr_stb_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (scs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (scs_fall) begin
                    state_d = INSTR;
                    bit_d = 3'd0;
                end
                INSTR: if (sck_rise) begin
                    shin_d = next_byte;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = DATA;
                        rw_d = next_byte[INSTR_RW];
                        nb_d = next_byte[INSTR_N_HI:INSTR_N_LO];
                        addr_d = next_byte[ADDR_W-1:0];
                        byte_d = 2'd0;
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shin_d = next_byte;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 2'd1;
                            state_d = (byte_q == nb_q) ? DONE : DATA;
                            if (!rw_q) begin
                                wr_stb_d = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = next_byte;
                                addr_d = addr_q - 5'd1;
                            end
                        end
                    end
`ifdef AD9783_SPI_READBACK_EN
                    if (rw_q && sck_fall && fbit_q == 3'd7) addr_d = addr_q - 5'd1;
`endif
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shin_q <= 8'd0;
            bit_q <= 3'd0;
            byte_q <= 2'd0;
            nb_q <= 2'd0;
            rw_q <= 1'b0;
            addr_q <= '0;
            wr_stb_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            reg_data_q <= 8'd0;
            for (int i = 0; i < N_REG; i++) regs_q[i] <= REG_RST;
        end else begin
            shin_q <= shin_d;
            bit_q <= bit_d;
            byte_q <= byte_d;
            nb_q <= nb_d;
            rw_q <= rw_d;
            addr_q <= addr_d;
            wr_stb_q <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            reg_data_q <= regs_q[reg_addr_in];
            if (wr_stb_d) regs_q[wr_addr_d] <= wr_data_d;
        end
    end
    assign reg_data_out = reg_data_q;
    assign wr_stb_out = wr_stb_q;
    assign wr_addr_out = wr_addr_q;
    assign wr_data_out = wr_data_q;
    assign busy_out = (state_q != IDLE);
endmodule

// File: tb/tb_ad9783_spi_responder.sv
// tb_ad9783_spi_responder: directed SPI transactions against a register-array and strobe-queue model.
module tb_ad9783_spi_responder;
    localparam int S = 2;
    logic clk = 1'b0, rst_n = 1'b0, scs = 1'b1, sck = 1'b0, sdo = 1'b0;
    logic [4:0] reg_addr = 5'd0;
    logic sdi, wr_stb, busy;
    logic [7:0] reg_data, wr_data;
    logic [4:0] wr_addr;
    int total = 0, bad = 0;
    logic [7:0] model [32];
    logic [12:0] exp_q [$];
    logic [31:0] rd;
    logic bsy, g;

    ad9783_spi_responder #(.SYNC_STAGES(S)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .spi_scs_in(scs), .spi_sck_in(sck), .spi_sdo_in(sdo),
        .spi_sdi_out(sdi), .reg_addr_in(reg_addr), .reg_data_out(reg_data),
        .wr_stb_out(wr_stb), .wr_addr_out(wr_addr), .wr_data_out(wr_data), .busy_out(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Every committed byte must match the next write the model predicted, in order.
    always @(negedge clk) begin
        if (rst_n && wr_stb) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h want none", wr_addr, wr_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, wr_addr}, {27'd0, e[12:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
`ifndef AD9783_SPI_READBACK_EN
        if (rst_n) chk("sdi_tied_zero", {31'd0, sdi}, 32'd0);
`endif
    end

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        model[a] = d;
    endtask

    task automatic send_bit(input logic b, output logic got);
        sdo = b;
        #50;
        got = sdi;
        sck = 1'b1;
        #50;
        sck = 1'b0;
    endtask

    task automatic txn(input logic [7:0] instr, input logic [31:0] data, input int nbits,
                       input int hold, output logic [31:0] r, output logic b);
        logic x;
        r = 32'd0;
        scs = 1'b0;
        #100;
        for (int i = 7; i >= 0; i--) send_bit(instr[i], x);
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[31-i], x);
            r = {r[30:0], x};
        end
        #(hold);
        b = busy;
        scs = 1'b1;
    endtask

    task automatic busy_drop();
        repeat (S + 2) @(posedge clk);
        #1 chk("busy_low_after_scs", {31'd0, busy}, 32'd0);
        #200;
    endtask

    task automatic rd_reg(input logic [4:0] a, input logic [7:0] exp);
        reg_addr = a;
        @(posedge clk);
        #1 chk($sformatf("reg_lit[%0d]", a), {24'd0, reg_data}, {24'd0, exp});
    endtask

    task automatic sweep();
        for (int a = 0; a < 32; a++) begin
            reg_addr = 5'(a);
            @(posedge clk);
            #1 chk($sformatf("reg[%0d]", a), {24'd0, reg_data}, {24'd0, model[a]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        #22;
        chk("rst_sdi", {31'd0, sdi}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_reg_data", {24'd0, reg_data}, 32'd0);
        #8 rst_n = 1'b1;
        #100;
        sweep();

        expect_wr(5'd5, 8'hA5);
        txn(8'h05, 32'hA500_0000, 8, 100, rd, bsy);
        chk("t1_busy_in_done", {31'd0, bsy}, 32'd1);
        busy_drop();
        chk("t1_pending", exp_q.size(), 32'd0);
        rd_reg(5'd5, 8'hA5);

        expect_wr(5'd1, 8'h11);
        expect_wr(5'd0, 8'h22);
        expect_wr(5'd31, 8'h33);
        expect_wr(5'd30, 8'h44);
        txn(8'h61, 32'h1122_3344, 32, 100, rd, bsy);
        busy_drop();
        chk("t2_pending", exp_q.size(), 32'd0);
        rd_reg(5'd1, 8'h11);
        rd_reg(5'd0, 8'h22);
        rd_reg(5'd31, 8'h33);
        rd_reg(5'd30, 8'h44);
        sweep();

        expect_wr(5'd16, 8'h3C);
        txn(8'h10, 32'h3C00_0000, 8, 100, rd, bsy);
        busy_drop();
`ifdef AD9783_SPI_READBACK_EN
        txn(8'h90, 32'h0000_0000, 8, 100, rd, bsy);
        busy_drop();
        chk("t3_read_3c", rd, 32'h0000_003C);
        txn(8'hA0, 32'hFFFF_FFFF, 17, 100, rd, bsy);
        busy_drop();
        chk("t3_read_wrap_lit", {16'd0, rd[16:1]}, 32'h0000_2233);
        chk("t3_read_wrap_model", {16'd0, rd[16:1]}, {16'd0, model[0], model[31]});
        chk("t3_done_sdi", {31'd0, rd[0]}, 32'd0);
        chk("t3_done_busy", {31'd0, bsy}, 32'd1);
`else
        txn(8'h85, 32'hFF80_0000, 9, 100, rd, bsy);
        busy_drop();
        chk("t3_noread_sdi", rd, 32'd0);
        chk("t3_noread_done_busy", {31'd0, bsy}, 32'd1);
`endif
        chk("t3_pending", exp_q.size(), 32'd0);

        txn(8'h02, 32'hF800_0000, 5, 0, rd, bsy);
        busy_drop();
        chk("t4_pending", exp_q.size(), 32'd0);
        rd_reg(5'd2, 8'h00);
        sweep();

        scs = 1'b0;
        #100;
        for (int i = 7; i >= 0; i--) send_bit(8'h90 >> i, g);
        for (int i = 0; i < 3; i++) send_bit(1'b0, g);
        #40;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sdi", {31'd0, sdi}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        scs = 1'b1;
        sck = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        #49 rst_n = 1'b1;
        #100;
        sweep();
        rd_reg(5'd16, 8'h00);
        chk("final_pending", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
